// File: rtl/ccu_ctrl_pkg.sv
// Shared snoop-side types: opcodes, CR response bit positions, channel structs and the response/update decode.
package ccu_ctrl_pkg;

    typedef enum logic [3:0] {
        SNP_READ_ONCE             = 4'b0000,
        SNP_READ_SHARED           = 4'b0001,
        SNP_READ_CLEAN            = 4'b0010,
        SNP_READ_NOT_SHARED_DIRTY = 4'b0011,
        SNP_READ_UNIQUE           = 4'b0111,
        SNP_CLEAN_SHARED          = 4'b1000,
        SNP_CLEAN_INVALID         = 4'b1001,
        SNP_MAKE_INVALID          = 4'b1101
    } snoop_op_e;

    localparam int unsigned CR_DATA_TRANSFER = 0;
    localparam int unsigned CR_ERROR         = 1;
    localparam int unsigned CR_PASS_DIRTY    = 2;
    localparam int unsigned CR_IS_SHARED     = 3;
    localparam int unsigned CR_WAS_UNIQUE    = 4;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOOKUP, ST_WAIT_LKP, ST_SEND_CR, ST_SEND_CD, ST_UPDATE
    } snoop_state_e;

    typedef struct packed {
        logic [63:0] addr;
        logic [3:0]  snoop;
    } ac_chan_t;

    typedef struct packed {
        logic [4:0] resp;
    } cr_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } cd_chan_t;

    // Returns {resp[4:0], upd_inval, upd_clean, upd_shared}; misses and unknown codes yield all zero.
    function automatic logic [7:0] snoop_resp(input logic [3:0] snoop, input logic hit,
                                              input logic dirty, input logic shared);
        logic [4:0] resp;
        logic       inval;
        logic       clean;
        logic       shd;
        resp  = '0;
        inval = 1'b0;
        clean = 1'b0;
        shd   = 1'b0;
        if (hit) begin
            resp[CR_WAS_UNIQUE] = !shared;
            case (snoop)
                SNP_READ_ONCE: begin
                    resp[CR_DATA_TRANSFER] = 1'b1;
                    resp[CR_IS_SHARED]     = 1'b1;
                end
                SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NOT_SHARED_DIRTY: begin
                    resp[CR_DATA_TRANSFER] = 1'b1;
                    resp[CR_IS_SHARED]     = 1'b1;
                    resp[CR_PASS_DIRTY]    = dirty;
                    shd   = 1'b1;
                    clean = dirty;
                end
                SNP_READ_UNIQUE: begin
                    resp[CR_DATA_TRANSFER] = 1'b1;
                    resp[CR_PASS_DIRTY]    = dirty;
                    inval = 1'b1;
                end
                SNP_CLEAN_SHARED: begin
                    resp[CR_DATA_TRANSFER] = dirty;
                    resp[CR_PASS_DIRTY]    = dirty;
                    resp[CR_IS_SHARED]     = 1'b1;
                    clean = dirty;
                end
                SNP_CLEAN_INVALID: begin
                    resp[CR_DATA_TRANSFER] = dirty;
                    resp[CR_PASS_DIRTY]    = dirty;
                    inval = 1'b1;
                end
                SNP_MAKE_INVALID: inval = 1'b1;
                default: resp = '0;
            endcase
        end
        return {resp, inval, clean, shd};
    endfunction

endpackage

// File: rtl/ace_snoop_responder.sv
// Cache-side ACE snoop responder: AC -> dcache lookup -> CR -> CD line beats -> line state update.
// Build option ACE_SNOOP_CRITICAL_WORD_FIRST_EN starts the CD burst at the addressed word.
module ace_snoop_responder
    import ccu_ctrl_pkg::*;
#(
    parameter int unsigned DcacheLineWidth = 128,
    parameter int unsigned AxiDataWidth    = 64,
    parameter int unsigned AddrWidth       = 64,
    parameter type         snoop_ac_t      = ccu_ctrl_pkg::ac_chan_t,
    parameter type         snoop_cr_t      = ccu_ctrl_pkg::cr_chan_t,
    parameter type         snoop_cd_t      = ccu_ctrl_pkg::cd_chan_t
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  snoop_ac_t                  ac_i,
    input  logic                       ac_valid_i,
    output logic                       ac_ready_o,
    output snoop_cr_t                  cr_o,
    output logic                       cr_valid_o,
    input  logic                       cr_ready_i,
    output snoop_cd_t                  cd_o,
    output logic                       cd_valid_o,
    input  logic                       cd_ready_i,
    output logic                       lkp_req_o,
    input  logic                       lkp_gnt_i,
    output logic [AddrWidth-1:0]       lkp_addr_o,
    input  logic                       lkp_valid_i,
    input  logic                       lkp_hit_i,
    input  logic                       lkp_dirty_i,
    input  logic                       lkp_shared_i,
    input  logic [DcacheLineWidth-1:0] lkp_data_i,
    output logic                       upd_valid_o,
    input  logic                       upd_ready_i,
    output logic                       upd_inval_o,
    output logic                       upd_clean_o,
    output logic                       upd_shared_o
);

    localparam int unsigned Words = DcacheLineWidth / AxiDataWidth;
    localparam int unsigned CntW  = $clog2(Words);
    localparam int unsigned OffW  = $clog2(DcacheLineWidth / 8);
    localparam logic [CntW-1:0] LastCnt = CntW'(Words - 1);

    snoop_state_e                          state_q, state_d;
    logic [AddrWidth-1:0]                  addr_q;
    logic [3:0]                            snoop_q;
    logic [4:0]                            resp_q;
    logic [2:0]                            upd_q;
    logic [Words-1:0][AxiDataWidth-1:0]    line_q;
    logic [CntW-1:0]                       cnt_q;
    logic [CntW-1:0]                       word_idx;
    logic                                  last_beat;

    assign last_beat = (cnt_q == LastCnt);

`ifdef ACE_SNOOP_CRITICAL_WORD_FIRST_EN
    localparam int unsigned     BeatOffW = $clog2(AxiDataWidth / 8);
    localparam logic [CntW:0]   WordsW   = (CntW + 1)'(Words);
    logic [CntW-1:0] start_q;
    logic [CntW:0]   idx_sum;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            start_q <= '0;
        end else if (state_q == ST_IDLE && ac_valid_i) begin
            start_q <= ac_i.addr[OffW-1:BeatOffW];
        end
    end

    // Beat counter stays 0-based so last is unaffected; only the word selection rotates.
    assign idx_sum  = {1'b0, cnt_q} + {1'b0, start_q};
    assign word_idx = (idx_sum >= WordsW) ? CntW'(idx_sum - WordsW) : CntW'(idx_sum);
`else
    assign word_idx = cnt_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (ac_valid_i)  state_d = ST_LOOKUP;
            ST_LOOKUP:   if (lkp_gnt_i)   state_d = ST_WAIT_LKP;
            ST_WAIT_LKP: if (lkp_valid_i) state_d = ST_SEND_CR;
            ST_SEND_CR: begin
                if (cr_ready_i) begin
                    if (resp_q[CR_DATA_TRANSFER]) state_d = ST_SEND_CD;
                    else if (upd_q != 3'b000)     state_d = ST_UPDATE;
                    else                          state_d = ST_IDLE;
                end
            end
            ST_SEND_CD: begin
                if (cd_ready_i && last_beat) begin
                    state_d = (upd_q != 3'b000) ? ST_UPDATE : ST_IDLE;
                end
            end
            ST_UPDATE:   if (upd_ready_i) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ac_ready_o   = 1'b0;
        lkp_req_o    = 1'b0;
        lkp_addr_o   = '0;
        cr_valid_o   = 1'b0;
        cr_o         = '0;
        cd_valid_o   = 1'b0;
        cd_o         = '0;
        upd_valid_o  = 1'b0;
        upd_inval_o  = 1'b0;
        upd_clean_o  = 1'b0;
        upd_shared_o = 1'b0;
        case (state_q)
            ST_IDLE:   ac_ready_o = 1'b1;
            ST_LOOKUP: begin
                lkp_req_o  = 1'b1;
                lkp_addr_o = {addr_q[AddrWidth-1:OffW], {OffW{1'b0}}};
            end
            ST_SEND_CR: begin
                cr_valid_o = 1'b1;
                cr_o.resp  = resp_q;
            end
            ST_SEND_CD: begin
                cd_valid_o = 1'b1;
                cd_o.data  = line_q[word_idx];
                cd_o.last  = last_beat;
            end
            ST_UPDATE: begin
                upd_valid_o = 1'b1;
                {upd_inval_o, upd_clean_o, upd_shared_o} = upd_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            snoop_q <= '0;
            resp_q  <= '0;
            upd_q   <= '0;
            line_q  <= '0;
            cnt_q   <= '0;
        end else begin
            if (state_q == ST_IDLE && ac_valid_i) begin
                addr_q  <= ac_i.addr;
                snoop_q <= ac_i.snoop;
                cnt_q   <= '0;
            end
            if (state_q == ST_WAIT_LKP && lkp_valid_i) begin
                {resp_q, upd_q} <= snoop_resp(snoop_q, lkp_hit_i, lkp_dirty_i, lkp_shared_i);
                line_q          <= lkp_data_i;
            end
            if (state_q == ST_SEND_CD && cd_ready_i) begin
                cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Directed bench for ace_snoop_responder (128-bit line, 64-bit CD): vector table plus backpressure and reset corners.
module tb_ace_snoop_responder;
    import ccu_ctrl_pkg::*;

    localparam logic [63:0] W0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] W1 = 64'hFEDC_BA98_7654_3210;
`ifdef ACE_SNOOP_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    ac_chan_t    ac = '0;
    logic        ac_valid = 1'b0, ac_ready;
    cr_chan_t    cr;
    logic        cr_valid, cr_ready = 1'b0;
    cd_chan_t    cd;
    logic        cd_valid, cd_ready = 1'b0;
    logic        lkp_req, lkp_gnt = 1'b0;
    logic [63:0] lkp_addr;
    logic        lkp_valid = 1'b0, lkp_hit = 1'b0, lkp_dirty = 1'b0, lkp_shared = 1'b0;
    logic [127:0] lkp_data = '0;
    logic        upd_valid, upd_ready = 1'b0, upd_inval, upd_clean, upd_shared;

    always #5 clk = ~clk;

    ace_snoop_responder #(.DcacheLineWidth(128), .AxiDataWidth(64), .AddrWidth(64)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ac_i(ac), .ac_valid_i(ac_valid), .ac_ready_o(ac_ready),
        .cr_o(cr), .cr_valid_o(cr_valid), .cr_ready_i(cr_ready),
        .cd_o(cd), .cd_valid_o(cd_valid), .cd_ready_i(cd_ready),
        .lkp_req_o(lkp_req), .lkp_gnt_i(lkp_gnt), .lkp_addr_o(lkp_addr),
        .lkp_valid_i(lkp_valid), .lkp_hit_i(lkp_hit), .lkp_dirty_i(lkp_dirty),
        .lkp_shared_i(lkp_shared), .lkp_data_i(lkp_data),
        .upd_valid_o(upd_valid), .upd_ready_i(upd_ready),
        .upd_inval_o(upd_inval), .upd_clean_o(upd_clean), .upd_shared_o(upd_shared)
    );

    int n_pass = 0;
    int n_total = 0;

    logic [4:0]  r_resp;
    int          r_beats;
    logic [63:0] r_data [4];
    logic        r_last [4];
    logic        r_upd_seen;
    logic [2:0]  r_upd;
    bit          r_stable;
    int          r_idle;
    bit          r_abort_ok;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [63:0] addr;
        logic        hit, dirty, shared;
        logic [4:0]  resp;
        int          beats;
        logic        upd_seen;
        logic [2:0]  upd;   // {inval, clean, shared}
    } vec_t;

    vec_t vt [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] exp_word(input logic [63:0] addr, input int beat);
        int start;
        start = CWF ? int'(addr[3]) : 0;
        return (((start + beat) % 2) == 1) ? W1 : W0;
    endfunction

    // Drives one snoop through to IDLE; cd backpressure on beat 0 for 'stall' cycles, or reset at first CD beat.
    task automatic run_snoop(input logic [3:0] op, input logic [63:0] addr, input logic hit,
                             input logic dirty, input logic shared, input int stall, input bit abort);
        int       st;
        cd_chan_t held;
        st = stall;
        held = '0;
        r_resp = '0; r_beats = 0; r_upd_seen = 1'b0; r_upd = '0;
        r_stable = 1'b1; r_idle = -1; r_abort_ok = 1'b0;
        @(negedge clk);
        ac_valid = 1'b1; ac.addr = addr; ac.snoop = op;
        @(negedge clk);
        ac_valid = 1'b0;
        check("lkp_req_latency", 64'(lkp_req), 64'd1);
        check("lkp_addr_aligned", lkp_addr, addr & ~64'hF);
        lkp_gnt = 1'b1;
        @(negedge clk);
        lkp_gnt = 1'b0;
        @(negedge clk);
        lkp_valid = 1'b1; lkp_hit = hit; lkp_dirty = dirty; lkp_shared = shared;
        lkp_data = {W1, W0};
        @(negedge clk);
        lkp_valid = 1'b0; lkp_hit = 1'b0; lkp_dirty = 1'b0; lkp_shared = 1'b0;
        check("cr_valid_latency", 64'(cr_valid), 64'd1);
        r_resp = cr.resp;
        cr_ready = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            cr_ready = 1'b0; cd_ready = 1'b0; upd_ready = 1'b0;
            if (ac_ready) begin
                r_idle = cyc;
                break;
            end
            if (cd_valid && abort) begin
                rst_n = 1'b0;
                #1;
                r_abort_ok = !cd_valid && ac_ready && !cr_valid && !upd_valid && !lkp_req && (cd === '0);
                @(negedge clk);
                rst_n = 1'b1;
                r_idle = cyc;
                break;
            end
            if (cd_valid) begin
                if (st > 0) begin
                    if (st == stall) held = cd;
                    else if (cd !== held) r_stable = 1'b0;
                    st--;
                end else begin
                    cd_ready = 1'b1;
                    if (r_beats < 4) begin
                        r_data[r_beats] = cd.data;
                        r_last[r_beats] = cd.last;
                    end
                    r_beats++;
                end
            end
            if (upd_valid) begin
                r_upd_seen = 1'b1;
                r_upd = {upd_inval, upd_clean, upd_shared};
                upd_ready = 1'b1;
            end
        end
    endtask

    initial begin
        vt[0]  = '{"rd_shared_dirty",  4'b0001, 64'h1000, 1'b1, 1'b1, 1'b0, 5'b11101, 2, 1'b1, 3'b011};
        vt[1]  = '{"rd_unique_clean",  4'b0111, 64'h1008, 1'b1, 1'b0, 1'b0, 5'b10001, 2, 1'b1, 3'b100};
        vt[2]  = '{"clean_inv_clean",  4'b1001, 64'h1040, 1'b1, 1'b0, 1'b0, 5'b10000, 0, 1'b1, 3'b100};
        vt[3]  = '{"miss_rd_shared",   4'b0001, 64'h1080, 1'b0, 1'b1, 1'b0, 5'b00000, 0, 1'b0, 3'b000};
        vt[4]  = '{"rd_once_shared",   4'b0000, 64'h10C0, 1'b1, 1'b0, 1'b1, 5'b01001, 2, 1'b0, 3'b000};
        vt[5]  = '{"clean_sh_dirty",   4'b1000, 64'h1100, 1'b1, 1'b1, 1'b1, 5'b01101, 2, 1'b1, 3'b010};
        vt[6]  = '{"clean_sh_clean",   4'b1000, 64'h1148, 1'b1, 1'b0, 1'b0, 5'b11000, 0, 1'b0, 3'b000};
        vt[7]  = '{"make_inv_dirty",   4'b1101, 64'h1180, 1'b1, 1'b1, 1'b0, 5'b10000, 0, 1'b1, 3'b100};
        vt[8]  = '{"unknown_op_hit",   4'b0101, 64'h11C0, 1'b1, 1'b1, 1'b0, 5'b00000, 0, 1'b0, 3'b000};
        vt[9]  = '{"rd_nsd_clean_sh",  4'b0011, 64'h1208, 1'b1, 1'b0, 1'b1, 5'b01001, 2, 1'b1, 3'b001};
        vt[10] = '{"rd_clean_dirty",   4'b0010, 64'h1240, 1'b1, 1'b1, 1'b1, 5'b01101, 2, 1'b1, 3'b011};
        vt[11] = '{"clean_inv_dirty",  4'b1001, 64'h1288, 1'b1, 1'b1, 1'b0, 5'b10101, 2, 1'b1, 3'b100};

        @(negedge clk);
        @(negedge clk);
        check("rst_ac_ready",  64'(ac_ready),  64'd1);
        check("rst_lkp_req",   64'(lkp_req),   64'd0);
        check("rst_cr_valid",  64'(cr_valid),  64'd0);
        check("rst_cd_valid",  64'(cd_valid),  64'd0);
        check("rst_upd_valid", 64'(upd_valid), 64'd0);
        check("rst_cr_resp",   64'(cr.resp),   64'd0);
        check("rst_cd",        64'(cd),        64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_snoop(vt[i].op, vt[i].addr, vt[i].hit, vt[i].dirty, vt[i].shared, 0, 1'b0);
            check({vt[i].name, "_resp"},     64'(r_resp),     64'(vt[i].resp));
            check({vt[i].name, "_beats"},    64'(r_beats),    64'(vt[i].beats));
            check({vt[i].name, "_upd_seen"}, 64'(r_upd_seen), 64'(vt[i].upd_seen));
            check({vt[i].name, "_upd"},      64'(r_upd),      64'(vt[i].upd));
            check({vt[i].name, "_done"},     64'(r_idle > 0), 64'd1);
            if (vt[i].beats == 2) begin
                check({vt[i].name, "_beat0"}, r_data[0], exp_word(vt[i].addr, 0));
                check({vt[i].name, "_beat1"}, r_data[1], exp_word(vt[i].addr, 1));
                check({vt[i].name, "_last"},  64'({r_last[0], r_last[1]}), 64'b01);
            end
            if (vt[i].resp == 5'b00000 && !vt[i].upd_seen) begin
                check({vt[i].name, "_idle_next"}, 64'(r_idle), 64'd1);
            end
        end

        run_snoop(4'b0001, 64'h2000, 1'b1, 1'b1, 1'b0, 5, 1'b0);
        check("bp_stable", 64'(r_stable), 64'd1);
        check("bp_beats",  64'(r_beats),  64'd2);
        check("bp_beat0",  r_data[0], W0);
        check("bp_beat1",  r_data[1], W1);
        check("bp_last",   64'({r_last[0], r_last[1]}), 64'b01);
        check("bp_upd",    64'(r_upd), 64'b011);

        run_snoop(4'b0001, 64'h3000, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        check("abort_outputs_reset", 64'(r_abort_ok), 64'd1);
        check("abort_ac_ready", 64'(ac_ready), 64'd1);

        run_snoop(4'b0111, 64'h3008, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        check("post_abort_resp",  64'(r_resp),  64'b10001);
        check("post_abort_beats", 64'(r_beats), 64'd2);
        check("post_abort_beat0", r_data[0], exp_word(64'h3008, 0));
        check("post_abort_upd",   64'(r_upd),   64'b100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
